// File: rtl/fifo_sync.sv
// Single-clock FIFO built on a registered-read RAM, with registered status flags
// and sticky overflow/underflow indicators.
module fifo_sync #(
  parameter int aw         = 4,
  parameter int dw         = 8,
  parameter int afull_lvl  = 12,
  parameter int aempty_lvl = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [dw-1:0] din,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic [aw:0]   count,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic          ovf,
  output logic          udf
);

  localparam int          depth     = 1 << aw;
  localparam logic [aw:0] depth_c   = (aw+1)'(depth);
  localparam logic [aw:0] afull_th  = (aw+1)'(afull_lvl);
  localparam logic [aw:0] aempty_th = (aw+1)'(aempty_lvl);
  localparam logic [aw:0] one_c     = (aw+1)'(1);

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;

  logic          pop_acc;
  logic          push_acc;
  logic [aw:0]   count_nxt;
  logic          full_nxt;
  logic          empty_nxt;
  logic          afull_nxt;
  logic          aempty_nxt;
  logic          ovf_nxt;
  logic          udf_nxt;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when paired with a real pop.
  always_comb begin
    pop_acc    = pop && !empty;
    push_acc   = push && (!full || pop_acc);
    count_nxt  = count;
    ovf_nxt    = ovf || (push && !push_acc);
    udf_nxt    = udf || (pop && empty);
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      udf_nxt   = 1'b0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_nxt = count + one_c;
        2'b01:   count_nxt = count - one_c;
        default: count_nxt = count;
      endcase
    end
    full_nxt   = (count_nxt == depth_c);
    empty_nxt  = (count_nxt == '0);
    afull_nxt  = (count_nxt >= afull_th);
    aempty_nxt = (count_nxt <= aempty_th);
  end

  // Control state: pointers, occupancy, flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_nxt;
      full   <= full_nxt;
      empty  <= empty_nxt;
      afull  <= afull_nxt;
      aempty <= aempty_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
    end
  end

  // Storage array is never reset; writes are blocked during reset and flush
  always_ff @(posedge clk) begin
    if (rst_n && !clr && push_acc) mem[wr_ptr] <= din;
  end

  // Registered read port; holds between accepted pops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!clr && pop_acc) begin
      dout <= mem[rd_ptr];
    end
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter aw, default 4, SHALL be the address width; depth = 2^aw entries.
REQ-002 Parameter dw, default 8, SHALL be the data width in bits.
REQ-003 Parameter afull_lvl, default 12, SHALL be the almost-full threshold in entries (legal range 1..2^aw).
REQ-004 Parameter aempty_lvl, default 2, SHALL be the almost-empty threshold in entries (legal range 0..2^aw-1).
REQ-005 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 clr  input  1  SHALL be the synchronous flush, active high.
REQ-008 push  input  1  SHALL be the write request, active high.
REQ-009 din  input  dw  SHALL be the write data, sampled on the edge where push is high.
REQ-010 pop  input  1  SHALL be the read request, active high.
REQ-011 dout  output  dw  SHALL be the registered read data.
REQ-012 count  output  aw+1  SHALL be the number of stored entries, 0..2^aw.
REQ-013 full, empty, afull, aempty  output  1 each  SHALL be the status flags.
REQ-014 ovf, udf  output  1 each  SHALL be the sticky overflow and underflow flags.

Function
REQ-015 Storage SHALL be a 2^aw x dw synchronous RAM array, with write and read addresses from aw-bit wr_ptr and rd_ptr.
REQ-016 A push SHALL be accepted iff push=1 and (full=0 or an accepted pop occurs in the same cycle); an accepted push writes din to mem[wr_ptr] and increments wr_ptr modulo 2^aw.
REQ-017 A pop SHALL be accepted iff pop=1 and empty=0; an accepted pop loads dout <= mem[rd_ptr] and increments rd_ptr modulo 2^aw.
REQ-018 Read latency SHALL be one cycle: data is on dout in the cycle after the accepted pop.
REQ-019 dout SHALL hold its value until the next accepted pop.
REQ-020 count SHALL update each cycle by (+1 on accepted push) + (-1 on accepted pop); it is unchanged when both are accepted.
REQ-021 Flags SHALL be registered and consistent with count after the same edge:
  - full = (count == 2^aw)
  - empty = (count == 0)
  - afull = (count >= afull_lvl)
  - aempty = (count <= aempty_lvl)
REQ-022 push=1 while full=1 with no accepted pop SHALL leave state unchanged and set ovf=1.
REQ-023 pop=1 while empty=1 SHALL leave rd_ptr and dout unchanged and set udf=1; a simultaneous push SHALL still be accepted.
REQ-024 push and pop both accepted while full SHALL keep count = 2^aw and full=1, with no ovf.
REQ-025 ovf and udf SHALL remain set until rst_n=0 or clr=1.
REQ-026 clr=1 SHALL, at the next edge:
  - set wr_ptr, rd_ptr and count to 0
  - set empty=1 and aempty=1; clear full, afull, ovf and udf
  - leave dout and memory unchanged
  - ignore push and pop in that cycle
REQ-027 Pointer wrap from 2^aw-1 to 0 SHALL be seamless, with no lost or duplicated entries.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL set:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, aempty=1
  - full=0, afull=0, ovf=0, udf=0
  - dout=0
REQ-029 rst_n SHALL take priority over clr, push and pop; memory contents are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; after release the FIFO behaves as empty.

Verification (aw=2, dw=8, afull_lvl=3, aempty_lvl=1)
REQ-031 Reset, then push 0x11,0x22,0x33,0x44 -> count 1..4; full=1 after the 4th push; afull=1 from count 3; aempty=0 from count 2.
REQ-032 From full, push 0x55 -> ovf=1, count=4; then four pops -> dout 0x11,0x22,0x33,0x44, each one cycle after its pop; empty=1.
REQ-033 From empty, pop -> udf=1, dout holds 0x44; same-cycle push 0xA5 with pop -> count=1, udf=1.
REQ-034 Full FIFO, push 0x66 + pop in the same cycle -> dout=0x11, count=4, ovf=0; continuing 8 cycles of push+pop -> in-order data across pointer wrap.
REQ-035 Count=3 with ovf=1, assert clr with push=1 -> count=0, empty=1, ovf=0, dout unchanged; then push 0x77 and pop -> dout=0x77.
REQ-036 Count=2, drive rst_n=0 and clr=1 together for one edge -> all reset values per REQ-028, including dout=0.
